qspi_tx_serializer: RTL and testbench

// - Drain side of the 32-bit TX FIFO. Pops words and shifts them out on the QSPI data lines
//   as single-bit (IO0) or quad (IO[3:0]) serial data, driving SCLK in SPI mode 0.
// - Sits between the TX FIFO and the QSPI pad drivers. Serves page-program and write data phases.

---
 rtl/qspi_tx_serializer.sv | 159 +++++++++++++++
 tb/tb_qspi_tx_serializer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_tx_serializer.sv
// qspi_tx_serializer: drain side of the 32-bit TX FIFO. Pops words and shifts them
// out MSB first on IO0 (single) or IO[3:0] (quad), with SCLK in SPI mode 0.
// Build option: define ENDIAN_SWAP_EN to send byte 0 of each FIFO word first.
module qspi_tx_serializer #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        quad,
    input  logic [8:0]  word_count,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_data,
    output logic        fifo_rd_en,
    output logic        sclk,
    output logic [3:0]  io_out,
    output logic [3:0]  io_oe,
    output logic        busy,
    output logic        done,
    output logic        underrun
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic        quad_q, quad_d;
    logic [8:0]  remain_q, remain_d;
    logic [31:0] sr_q, sr_d;
    logic [4:0]  slot_q, slot_d;
    logic [7:0]  div_q, div_d;
    logic        sclk_q, sclk_d;
    logic        underrun_q, underrun_d;
    logic [31:0] load_word;
    logic [4:0]  last_slot;

`ifdef ENDIAN_SWAP_EN
    assign load_word = {fifo_data[7:0], fifo_data[15:8], fifo_data[23:16], fifo_data[31:24]};
`else
    assign load_word = fifo_data;
`endif

    assign last_slot = quad_q ? 5'd7 : 5'd31;

    // The final slot of a word is not shifted away, so io_out holds through FETCH.
    assign io_out   = quad_q ? sr_q[31:28] : {3'b000, sr_q[31]};
    assign sclk     = sclk_q;
    assign underrun = underrun_q;

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            quad_q     <= 1'b0;
            remain_q   <= '0;
            sr_q       <= '0;
            slot_q     <= '0;
            div_q      <= '0;
            sclk_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            quad_q     <= quad_d;
            remain_q   <= remain_d;
            sr_q       <= sr_d;
            slot_q     <= slot_d;
            div_q      <= div_d;
            sclk_q     <= sclk_d;
            underrun_q <= underrun_d;
        end
    end

    // Next-state, SCLK generation, shifting and handshake outputs
    always_comb begin
        state_d    = state_q;
        quad_d     = quad_q;
        remain_d   = remain_q;
        sr_d       = sr_q;
        slot_d     = slot_q;
        div_d      = div_q;
        sclk_d     = sclk_q;
        underrun_d = underrun_q;
        fifo_rd_en = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        io_oe      = 4'b0000;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    underrun_d = 1'b0;
                    if (word_count != 9'd0) begin
                        quad_d   = quad;
                        remain_d = word_count;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                busy = 1'b1;
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = S_LOAD;
                end else begin
                    underrun_d = 1'b1;
                end
            end
            S_LOAD: begin
                busy    = 1'b1;
                sr_d    = load_word;
                slot_d  = '0;
                div_d   = '0;
                sclk_d  = 1'b0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                busy  = 1'b1;
                div_d = div_q + 8'd1;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (slot_q == last_slot) begin
                            slot_d   = '0;
                            remain_d = remain_q - 9'd1;
                            state_d  = (remain_q == 9'd1) ? S_DONE : S_FETCH;
                        end else begin
                            slot_d = slot_q + 5'd1;
                            sr_d   = quad_q ? {sr_q[27:0], 4'b0000} : {sr_q[30:0], 1'b0};
                        end
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (busy) begin
            io_oe = quad_q ? 4'b1111 : 4'b0001;
        end
    end

endmodule

// File: tb/tb_qspi_tx_serializer.sv
// Self-checking bench for qspi_tx_serializer: a queue-based FIFO, a slot-list model of
// the serial stream, a per-cycle monitor, and directed transfers with literal expectations.
`timescale 1ns/1ps
module tb_qspi_tx_serializer;

    localparam int unsigned CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        quad = 1'b0;
    logic [8:0]  word_count = '0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = '0;
    logic        fifo_rd_en;
    logic        sclk;
    logic [3:0]  io_out;
    logic [3:0]  io_oe;
    logic        busy;
    logic        done;
    logic        underrun;

    qspi_tx_serializer #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .quad       (quad),
        .word_count (word_count),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .sclk       (sclk),
        .io_out     (io_out),
        .io_oe      (io_oe),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] fifo_q[$];
    logic [3:0]  exp_q[$];
    logic [3:0]  cap_q[$];
    logic        cur_quad = 1'b0;

    int rise_cnt = 0;
    int hi_cycles = 0;
    int hi_run = 0;
    int done_cnt = 0;
    int rd_cnt = 0;
    logic       prev_sclk = 1'b0;
    logic       prev_rd = 1'b0;
    logic       prev_done = 1'b0;
    logic [3:0] prev_io = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: condition not met (t=%0t)", name, $time);
    endtask

    // FIFO model: pop on rd_en, data valid the next cycle, empty flag tracks contents
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Stream model: list of pad values expected at successive SCLK rising edges
    task automatic model_word(input logic [31:0] w, input logic qd);
        logic [31:0] s;
        s = w;
`ifdef ENDIAN_SWAP_EN
        s = {<<8{w}};
`endif
        if (qd) begin
            for (int i = 0; i < 8; i++) exp_q.push_back(4'((s >> (28 - 4 * i)) & 32'hF));
        end else begin
            for (int i = 0; i < 32; i++) exp_q.push_back({3'b000, s[31 - i]});
        end
    endtask

    // Per-cycle monitor
    always @(negedge clk) begin
        if (!rst) begin
            check("io_oe", {28'd0, io_oe}, busy ? (cur_quad ? 32'hF : 32'h1) : 32'h0);
            if (!busy) check("sclk_idle_low", {31'd0, sclk}, 32'd0);
            if (fifo_rd_en) begin
                rd_cnt++;
                check("rd_en_spacing", {31'd0, prev_rd}, 32'd0);
            end
            if (done) begin
                done_cnt++;
                check("done_width", {31'd0, prev_done}, 32'd0);
                check("done_all_slots_sent", exp_q.size(), 32'd0);
                check("done_busy_low", {31'd0, busy}, 32'd0);
            end
            if (sclk) begin
                hi_cycles++;
                hi_run++;
            end
            if (sclk && !prev_sclk) begin
                rise_cnt++;
                cap_q.push_back(io_out);
                check("io_stable_at_rise", {28'd0, io_out}, {28'd0, prev_io});
                if (exp_q.size() == 0) fail("unexpected_sclk_rise");
                else check("io_out_slot", {28'd0, io_out}, {28'd0, exp_q.pop_front()});
            end
            if (!sclk && prev_sclk) begin
                check("sclk_high_len", hi_run, CLK_DIV);
                hi_run = 0;
            end
        end else begin
            hi_run = 0;
        end
        prev_sclk = sclk;
        prev_rd   = fifo_rd_en;
        prev_done = done;
        prev_io   = io_out;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic qd, input logic [8:0] cnt);
        @(posedge clk);
        #1;
        start = 1'b1;
        quad = qd;
        word_count = cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    logic [3:0]  nib1 [8];
    logic [3:0]  nib6 [8];
    logic [63:0] stream2_exp;
    logic [63:0] stream2_got;
    int r0, h0, d0, c0;

    initial begin
`ifdef ENDIAN_SWAP_EN
        nib1 = '{4'h7, 4'hF, 4'h1, 4'hE, 4'hC, 4'h3, 4'hA, 4'h5};
        nib6 = '{4'h4, 4'h4, 4'h3, 4'h3, 4'h2, 4'h2, 4'h1, 4'h1};
        stream2_exp = 64'h0100_0080_0000_FFFF;
`else
        nib1 = '{4'hA, 4'h5, 4'hC, 4'h3, 4'h1, 4'hE, 4'h7, 4'hF};
        nib6 = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4};
        stream2_exp = 64'h8000_0001_FFFF_0000;
`endif

        // Reset state
        repeat (3) tick();
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_io_out", {28'd0, io_out}, 32'd0);
        check("rst_io_oe", {28'd0, io_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        rst = 1'b0;
        tick();

        // Quad, one word, with latency checks
        cur_quad = 1'b1;
        fifo_q.push_back(32'hA5C3_1E7F);
        model_word(32'hA5C3_1E7F, 1'b1);
        cap_q.delete();
        r0 = rise_cnt; h0 = hi_cycles; d0 = done_cnt; c0 = rd_cnt;
        pulse_start(1'b1, 9'd1);
        check("t1_rd_en_T1", {31'd0, fifo_rd_en}, 32'd1);
        check("t1_busy_T1", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check("t1_rd_en_T2", {31'd0, fifo_rd_en}, 32'd0);
        @(posedge clk); #1;
        check("t1_first_nibble_T3", {28'd0, io_out}, {28'd0, nib1[0]});
        check("t1_sclk_low_T3", {31'd0, sclk}, 32'd0);
        wait_done("t1", 200);
        check("t1_rises", rise_cnt - r0, 32'd8);
        check("t1_sclk_high_cycles", hi_cycles - h0, 8 * CLK_DIV);
        check("t1_rd_pulses", rd_cnt - c0, 32'd1);
        check("t1_done_pulses", done_cnt - d0, 32'd1);
        check("t1_cap_len", cap_q.size(), 32'd8);
        for (int i = 0; i < 8 && i < cap_q.size(); i++)
            check("t1_nibble_lit", {28'd0, cap_q[i]}, {28'd0, nib1[i]});
        tick();
        check("t1_busy_after", {31'd0, busy}, 32'd0);

        // Single, two words
        cur_quad = 1'b0;
        fifo_q.push_back(32'h8000_0001);
        fifo_q.push_back(32'hFFFF_0000);
        model_word(32'h8000_0001, 1'b0);
        model_word(32'hFFFF_0000, 1'b0);
        cap_q.delete();
        d0 = done_cnt; c0 = rd_cnt;
        pulse_start(1'b0, 9'd2);
        wait_done("t2", 500);
        check("t2_cap_len", cap_q.size(), 32'd64);
        stream2_got = '0;
        for (int i = 0; i < 64 && i < cap_q.size(); i++) stream2_got[63 - i] = cap_q[i][0];
        check("t2_stream_hi", stream2_got[63:32], stream2_exp[63:32]);
        check("t2_stream_lo", stream2_got[31:0], stream2_exp[31:0]);
        check("t2_rd_pulses", rd_cnt - c0, 32'd2);
        check("t2_done_pulses", done_cnt - d0, 32'd1);

        // Underrun: one word available, refill after a 20-cycle stall
        cur_quad = 1'b1;
        fifo_q.push_back(32'h0F0F_1234);
        model_word(32'h0F0F_1234, 1'b1);
        model_word(32'hDEAD_BEEF, 1'b1);
        model_word(32'h1357_9BDF, 1'b1);
        r0 = rise_cnt; d0 = done_cnt; c0 = rd_cnt;
        pulse_start(1'b1, 9'd3);
        for (int n = 0; n < 200 && underrun !== 1'b1; n++) tick();
        check("t3_underrun_set", {31'd0, underrun}, 32'd1);
        for (int n = 0; n < 20; n++) begin
            tick();
            check("t3_stall_sclk_low", {31'd0, sclk}, 32'd0);
            check("t3_stall_busy", {31'd0, busy}, 32'd1);
        end
        fifo_q.push_back(32'hDEAD_BEEF);
        fifo_q.push_back(32'h1357_9BDF);
        wait_done("t3", 300);
        check("t3_underrun_sticky", {31'd0, underrun}, 32'd1);
        check("t3_rises", rise_cnt - r0, 32'd24);
        check("t3_rd_pulses", rd_cnt - c0, 32'd3);
        check("t3_done_pulses", done_cnt - d0, 32'd1);

        // Reset at the 5th SCLK rise of a quad word, then a clean transfer
        fifo_q.push_back(32'hCAFE_F00D);
        fifo_q.push_back(32'h1234_5678);
        model_word(32'hCAFE_F00D, 1'b1);
        model_word(32'h1234_5678, 1'b1);
        r0 = rise_cnt; d0 = done_cnt;
        pulse_start(1'b1, 9'd2);
        check("t4_underrun_cleared", {31'd0, underrun}, 32'd0);
        for (int n = 0; n < 100 && (rise_cnt - r0) < 5; n++) tick();
        check("t4_reached_5th_rise", rise_cnt - r0, 32'd5);
        rst = 1'b1;
        tick();
        check("t4_rst_sclk", {31'd0, sclk}, 32'd0);
        check("t4_rst_io_oe", {28'd0, io_oe}, 32'd0);
        check("t4_rst_busy", {31'd0, busy}, 32'd0);
        check("t4_rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        fifo_q.delete();
        repeat (5) tick();
        check("t4_no_done_after_rst", done_cnt - d0, 32'd0);
        fifo_q.push_back(32'h0BAD_CAFE);
        model_word(32'h0BAD_CAFE, 1'b1);
        r0 = rise_cnt; d0 = done_cnt;
        pulse_start(1'b1, 9'd1);
        wait_done("t4_restart", 200);
        check("t4_restart_rises", rise_cnt - r0, 32'd8);
        check("t4_restart_done", done_cnt - d0, 32'd1);

        // Start while busy is ignored; zero-length start finishes at once
        fifo_q.push_back(32'h3C3C_A5A5);
        model_word(32'h3C3C_A5A5, 1'b1);
        r0 = rise_cnt; d0 = done_cnt; c0 = rd_cnt;
        pulse_start(1'b1, 9'd1);
        repeat (10) tick();
        pulse_start(1'b0, 9'd5);
        wait_done("t5", 200);
        check("t5_rises", rise_cnt - r0, 32'd8);
        check("t5_rd_pulses", rd_cnt - c0, 32'd1);
        check("t5_done_pulses", done_cnt - d0, 32'd1);
        repeat (3) tick();
        d0 = done_cnt; c0 = rd_cnt;
        pulse_start(1'b0, 9'd0);
        check("t5_zero_done_next", {31'd0, done}, 32'd1);
        check("t5_zero_busy_low", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        check("t5_zero_done_once", done_cnt - d0, 32'd1);
        check("t5_zero_no_pop", rd_cnt - c0, 32'd0);
        check("t5_zero_done_clear", {31'd0, done}, 32'd0);

        // Byte-order pin
        cur_quad = 1'b1;
        fifo_q.push_back(32'h1122_3344);
        model_word(32'h1122_3344, 1'b1);
        cap_q.delete();
        pulse_start(1'b1, 9'd1);
        wait_done("t6", 200);
        check("t6_cap_len", cap_q.size(), 32'd8);
        for (int i = 0; i < 8 && i < cap_q.size(); i++)
            check("t6_nibble_lit", {28'd0, cap_q[i]}, {28'd0, nib6[i]});

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
